// File: rtl/dcache_pkg.sv
// Shared sizing constants and the response record used by the 4 KB data cache.
// The response id field is sized for the widest supported tag; narrower tags are zero-extended.
package dcache_pkg;
  localparam int DCACHE_BYTES    = 4096;
  localparam int DCACHE_WORDS    = 1024;
  localparam int DCACHE_IDX_W    = 10;
  localparam int WORD_W          = 32;
  localparam int DCACHE_ID_MAX_W = 8;

  typedef struct packed {
    logic                       valid;
    logic [DCACHE_ID_MAX_W-1:0] id;
    logic [WORD_W-1:0]          data;
  } dcache_resp_t;
endpackage

// File: rtl/dcache_4kb_if.sv
// Load/store request and tagged completion bundle between the LSQ and the data cache.
interface dcache_4kb_if #(
  parameter int ID_W = 4
);
  logic            memR;
  logic            memW;
  logic [ID_W-1:0] ldstID;
  logic [31:0]     addr;
  logic [31:0]     Wdata;
  logic [31:0]     Rdata;
  logic [ID_W-1:0] ldstID_out;
  logic            ready_out;

  modport master (
    output memR, memW, ldstID, addr, Wdata,
    input  Rdata, ldstID_out, ready_out
  );

  modport slave (
    input  memR, memW, ldstID, addr, Wdata,
    output Rdata, ldstID_out, ready_out
  );
endinterface

// File: rtl/dcache_resp_pipe.sv
// Delay line for completions; each stage keeps its id/data when idle so the
// final stage holds the last completed values while ready is low.
module dcache_resp_pipe
  import dcache_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  dcache_resp_t in_i,
  output dcache_resp_t out_o
);
  dcache_resp_t tap [DEPTH+1];

  assign tap[0] = in_i;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      dcache_resp_t stg_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          stg_q <= '0;
        end else if (tap[gi].valid) begin
          stg_q <= tap[gi];
        end else begin
          stg_q.valid <= 1'b0;
        end
      end

      assign tap[gi+1] = stg_q;
    end
  endgenerate

  assign out_o = tap[DEPTH];
endmodule

// File: rtl/dcache_4kb.sv
// 4 KB single-ported L1 data memory: one tagged load/store per cycle, in-order
// completions LATENCY cycles later. The RAM read register forms the first stage.
module dcache_4kb
  import dcache_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  dcache_4kb_if.slave bus
);
  logic [WORD_W-1:0]       mem_q [DCACHE_WORDS];
  logic [DCACHE_IDX_W-1:0] idx;
  logic                    wr_en;
  logic                    rd_en;
  logic                    valid_q;
  logic                    store_q;
  logic [ID_W-1:0]         id_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [WORD_W-1:0]       rdata_q;
  dcache_resp_t            head;
  dcache_resp_t            tail;
  logic                    unused_ok;

  assign idx   = bus.addr[DCACHE_IDX_W+1:2];
  assign wr_en = ~rst & bus.memW;
  assign rd_en = ~rst & bus.memR & ~bus.memW;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= bus.Wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[idx];
    end
  end

  // Tag/select registers only load on a request so an idle cycle keeps the last completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      store_q <= 1'b0;
      id_q    <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= wr_en | rd_en;
      if (wr_en | rd_en) begin
        store_q <= wr_en;
        id_q    <= bus.ldstID;
      end
      if (wr_en) begin
        wdata_q <= bus.Wdata;
      end
    end
  end

  always_comb begin
    head       = '0;
    head.valid = valid_q;
    head.id    = DCACHE_ID_MAX_W'(id_q);
    head.data  = store_q ? wdata_q : rdata_q;
  end

  dcache_resp_pipe #(
    .DEPTH(LATENCY - 1)
  ) u_resp_pipe (
    .clk  (clk),
    .rst  (rst),
    .in_i (head),
    .out_o(tail)
  );

  assign bus.ready_out  = tail.valid;
  assign bus.Rdata      = tail.data;
  assign bus.ldstID_out = tail.id[ID_W-1:0];

  assign unused_ok = ^{bus.addr[31:DCACHE_IDX_W+2], bus.addr[1:0],
                       tail.id[DCACHE_ID_MAX_W-1:ID_W]};
endmodule

// File: tb/tb_dcache_4kb.sv
// Scoreboard bench: two cache instances (LATENCY 1 and 2) share one request stream;
// expected completions are queued at issue and popped when each instance is due.
module tb_dcache_4kb;
  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        memR, memW;
  logic [3:0]  ldstID;
  logic [31:0] addr, Wdata;

  int          cyc;
  logic        rst_q;
  int          n_checks;
  int          n_errors;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [1024];
  bit          written [1024];
  logic [31:0] last_data [2];
  logic [3:0]  last_id [2];

  dcache_4kb_if #(.ID_W(4)) b0 ();
  dcache_4kb_if #(.ID_W(4)) b1 ();

  assign b0.memR = memR;   assign b1.memR = memR;
  assign b0.memW = memW;   assign b1.memW = memW;
  assign b0.ldstID = ldstID; assign b1.ldstID = ldstID;
  assign b0.addr = addr;   assign b1.addr = addr;
  assign b0.Wdata = Wdata; assign b1.Wdata = Wdata;

  dcache_4kb #(.ID_W(4), .LATENCY(1)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dcache_4kb #(.ID_W(4), .LATENCY(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One call per instance per cycle, on the falling edge.
  task automatic mon(input int d, input logic rdy, input logic [31:0] rd, input logic [3:0] idv);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '{id: 4'd0, data: 32'd0, due: 0};
    if (rst_q) begin
      if (d == 0) begin
        while (q0.size() > 0 && q0[$].due >= cyc) void'(q0.pop_back());
      end else begin
        while (q1.size() > 0 && q1[$].due >= cyc) void'(q1.pop_back());
      end
      last_data[d] = 32'd0;
      last_id[d]   = 4'd0;
    end
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].due <= cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    check($sformatf("lat%0d ready", d + 1), {31'd0, rdy}, {31'd0, have});
    if (rdy && have) begin
      check($sformatf("lat%0d id", d + 1), {28'd0, idv}, {28'd0, e.id});
      check($sformatf("lat%0d data id%0d", d + 1, e.id), rd, e.data);
      last_data[d] = e.data;
      last_id[d]   = e.id;
    end else if (!rdy) begin
      check($sformatf("lat%0d hold data", d + 1), rd, last_data[d]);
      check($sformatf("lat%0d hold id", d + 1), {28'd0, idv}, {28'd0, last_id[d]});
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.ready_out, b0.Rdata, b0.ldstID_out);
    mon(1, b1.ready_out, b1.Rdata, b1.ldstID_out);
  end

  task automatic issue(input bit r, input bit w, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] wd, input bit rs);
    logic [31:0] ev;
    int          wi;
    @(posedge clk);
    #2;
    rst    = rs;
    memR   = r;
    memW   = w;
    ldstID = id;
    addr   = a;
    Wdata  = wd;
    wi     = int'(a[11:2]);
    if (!rs && (r || w)) begin
      if (w) begin
        ev          = wd;
        model[wi]   = wd;
        written[wi] = 1'b1;
      end else begin
        ev = model[wi];
      end
      q0.push_back('{id: id, data: ev, due: cyc + 1});
      q1.push_back('{id: id, data: ev, due: cyc + 2});
      $display("issue %s id=%0d addr=%h wdata=%h expect=%h", w ? "store" : "load ", id, a, wd, ev);
    end else if (rs && (r || w)) begin
      $display("issue %s id=%0d addr=%h during reset (ignored)", w ? "store" : "load ", id, a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    cyc = 0; rst_q = 1'b0; n_checks = 0; n_errors = 0;
    rst = 1'b1; memR = 1'b0; memW = 1'b0; ldstID = 4'd0; addr = 32'd0; Wdata = 32'd0;
    last_data[0] = 32'd0; last_data[1] = 32'd0; last_id[0] = 4'd0; last_id[1] = 4'd0;
    for (int i = 0; i < 1024; i++) begin model[i] = 32'd0; written[i] = 1'b0; end

    for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(2);

    // basic store
    issue(1'b0, 1'b1, 4'd1, 32'd40, 32'd9000, 1'b0);
    idle(3);
    // back-to-back stores and loads
    issue(1'b0, 1'b1, 4'd2, 32'd40, 32'd9000, 1'b0);
    issue(1'b0, 1'b1, 4'd3, 32'd44, 32'd9001, 1'b0);
    issue(1'b1, 1'b0, 4'd4, 32'd40, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 4'd5, 32'd44, 32'd0, 1'b0);
    idle(3);
    // read-after-write on consecutive cycles
    issue(1'b0, 1'b1, 4'd6, 32'd80, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 4'd7, 32'd80, 32'd0, 1'b0);
    idle(2);
    // aliasing plus ignored byte offset
    issue(1'b0, 1'b1, 4'd8, 32'h0000_1042, 32'h55, 1'b0);
    issue(1'b1, 1'b0, 4'd10, 32'h0000_0040, 32'd0, 1'b0);
    idle(2);
    // both strobes act as a store
    issue(1'b1, 1'b1, 4'd9, 32'd8, 32'h77, 1'b0);
    idle(1);
    issue(1'b1, 1'b0, 4'd11, 32'hFFFF_F008, 32'd0, 1'b0);
    idle(3);

    // reset while a load is in flight; requests held during reset are dropped
    issue(1'b1, 1'b0, 4'd12, 32'd40, 32'd0, 1'b0);
    issue(1'b0, 1'b1, 4'd13, 32'd40, 32'h0BAD, 1'b1);
    issue(1'b1, 1'b0, 4'd14, 32'd44, 32'd0, 1'b1);
    idle(2);
    issue(1'b1, 1'b0, 4'd15, 32'd40, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 4'd0, 32'd80, 32'd0, 1'b0);
    idle(3);

    // random mix over a few aliased words, with occasional gaps
    for (int i = 0; i < 60; i++) begin
      int          k;
      logic [31:0] a;
      bit          w;
      k = $urandom_range(0, 7);
      a = {$urandom_range(0, 255), 12'h000} | (32'h100 + 32'(k * 4)) | 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 1) || !written[int'(a[11:2])];
      if ($urandom_range(0, 5) == 0) idle(1);
      issue(w ? 1'($urandom_range(0, 1)) : 1'b1, w, 4'($urandom_range(0, 15)), a, $urandom, 1'b0);
    end
    idle(4);

    check("lat1 drained", q0.size(), 32'd0);
    check("lat2 drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
